// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame states, frame
// geometry and the baud-rate select codes.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int TICKS_PER_BIT = 16;
  localparam int DATA_BITS     = 8;

  localparam logic [1:0] BAUD_1200 = 2'b00;
  localparam logic [1:0] BAUD_2400 = 2'b01;
  localparam logic [1:0] BAUD_4800 = 2'b10;
  localparam logic [1:0] BAUD_9600 = 2'b11;

endpackage

// File: rtl/uart_tx_shift.sv
// Frame serializer: one start bit, eight data bits LSB first, one stop bit.
// Each bit lasts TICKS_PER_BIT pulses of s_tick. Ticks are ignored while idle,
// so the first bit period is measured from the first tick after loading.
module uart_tx_shift
  import uart_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_s_tick,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  uart_state_e r_state;
  uart_state_e w_state_nxt;
  logic [3:0]  r_tick_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        w_bit_end;

  // A bit period ends on the tick that completes the sixteenth count.
  assign w_bit_end = i_s_tick && (r_tick_cnt == 4'(TICKS_PER_BIT - 1));

  // Frame state register.
  always_ff @(posedge clock) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and line outputs, all derived from the current state.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    w_state_nxt = r_state;
    o_tx        = 1'b1;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_load) w_state_nxt = ST_START;
      end
      ST_START: begin
        o_tx = 1'b0;
        if (w_bit_end) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        o_tx = r_shift[0];
        if (w_bit_end && (r_bit_cnt == 3'(DATA_BITS - 1))) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = ST_IDLE;
          o_done      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Tick/bit counters and shift register; frozen whenever s_tick is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else if (r_state == ST_IDLE) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      if (i_load) r_shift <= i_data;
    end else if (i_s_tick) begin
      // Wraps 15 -> 0 exactly when a bit period ends.
      r_tick_cnt <= r_tick_cnt + 4'd1;
      if (w_bit_end && (r_state == ST_DATA)) begin
        r_shift   <= {1'b0, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ byte sources with round-robin
// arbitration, and sequences baud-rate changes so the rate only moves while
// the line is idle. A change requested mid-frame is held and applied on the
// first idle cycle; no byte is accepted in that cycle.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
)(
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              s_tick,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_baud,
  output logic [1:0]        baud_rate,
  output logic              tx,
  output logic              busy,
  output logic [GW-1:0]     grant_id
);

  logic [GW-1:0] r_grant_id;
  logic [1:0]    r_baud;
  logic          r_pend_valid;
  logic [1:0]    r_pend_baud;
  logic          r_cfg_hold;

  logic          w_busy;
  logic          w_done;
  logic          w_win_valid;
  logic [GW-1:0] w_win_idx;
  logic [GW-1:0] w_cand;
  logic          w_xfer;
  logic [7:0]    w_byte;

  // Round-robin search: first valid requester after the last grant, wrapping.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = GW'((int'(r_grant_id) + k) % NREQ);
      if (!w_win_valid && req_valid[w_cand]) begin
        w_win_valid = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  // Byte of the current winner.
  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win_idx == GW'(i)) w_byte = req_data[8*i +: 8];
    end
  end

  // Offers are made only when idle and no rate change is being taken.
  assign w_xfer    = !reset && !w_busy && !cfg_wr && !r_cfg_hold && w_win_valid;
  assign req_ready = w_xfer ? (NREQ'(1) << w_win_idx) : '0;

  // Grant pointer and baud-rate sequencing.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_grant_id   <= GW'(NREQ - 1);
      r_baud       <= BAUD_1200;
      r_pend_valid <= 1'b0;
      r_pend_baud  <= BAUD_1200;
      r_cfg_hold   <= 1'b0;
    end else begin
      if (w_xfer) r_grant_id <= w_win_idx;
      if (!w_busy) begin
        r_cfg_hold <= 1'b0;
        if (cfg_wr) r_baud <= cfg_baud;
      end else begin
        if (cfg_wr) begin
          r_pend_valid <= 1'b1;
          r_pend_baud  <= cfg_baud;
        end
        // The held rate lands on the edge that ends STOP, so it is visible
        // in the first idle cycle and never while busy.
        if (w_done && (cfg_wr || r_pend_valid)) begin
          r_baud       <= cfg_wr ? cfg_baud : r_pend_baud;
          r_pend_valid <= 1'b0;
          r_cfg_hold   <= 1'b1;
        end
      end
    end
  end

  uart_tx_shift u_shift (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_xfer),
    .i_data   (w_byte),
    .i_s_tick (s_tick),
    .o_tx     (tx),
    .o_busy   (w_busy),
    .o_done   (w_done)
  );

  assign busy      = w_busy;
  assign baud_rate = r_baud;
  assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. A lockstep reference model tracks the frame as
// "ticks consumed since the start bit" and the arbitration as a rotating
// priority list; scenario tasks add their own targeted comparisons.
module tb_uart_tx_arbiter;

  localparam int NREQ        = 4;
  localparam int GW          = 2;
  localparam int FRAME_TICKS = 160;

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              s_tick;
  logic              cfg_wr;
  logic [1:0]        cfg_baud;
  logic [1:0]        baud_rate;
  logic              tx;
  logic              busy;
  logic [GW-1:0]     grant_id;

  uart_tx_arbiter #(.NREQ(NREQ)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .s_tick    (s_tick),
    .cfg_wr    (cfg_wr),
    .cfg_baud  (cfg_baud),
    .baud_rate (baud_rate),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic       m_busy;
  int         m_pos;
  logic [7:0] m_byte;
  int         m_grant;
  logic [1:0] m_baud;
  logic       m_pend_valid;
  logic [1:0] m_pend;
  logic       m_hold;

  // Per-cycle observations
  logic [NREQ-1:0]    exp_ready, obs_ready;
  logic               exp_tx, obs_tx, obs_busy;
  logic [1:0]         obs_baud;
  logic [GW-1:0]      obs_grant;
  logic [NREQ+GW+3:0] exp_vec, obs_vec;

  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v, input int last);
    logic [NREQ-1:0] r;
    r = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (r == '0 && v[(last + k) % NREQ]) r[(last + k) % NREQ] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    int n;
    n = pos / 16;
    if (n == 0) return 1'b0;
    if (n <= 8) return b[n-1];
    return 1'b1;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_pos = 0; m_byte = '0; m_grant = NREQ - 1;
    m_baud = 2'b00; m_pend_valid = 1'b0; m_pend = 2'b00; m_hold = 1'b0;
  endtask

  // One clock: compare all outputs against the model mid-cycle, then advance
  // both the DUT and the model with the inputs held for this cycle.
  task automatic step(input string tag);
    int idx;
    #1;
    exp_ready = (reset || m_busy || cfg_wr || m_hold) ? '0 : rr_pick(req_valid, m_grant);
    exp_tx    = m_busy ? frame_bit(m_byte, m_pos) : 1'b1;
    exp_vec   = {exp_ready, exp_tx, m_busy, m_baud, m_grant[GW-1:0]};
    obs_ready = req_ready; obs_tx = tx; obs_busy = busy;
    obs_baud  = baud_rate; obs_grant = grant_id;
    obs_vec   = {req_ready, tx, busy, baud_rate, grant_id};
    n_tests++;
    if (obs_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL %s t=%0t {ready,tx,busy,baud,grant} got %b want %b", tag, $time, obs_vec, exp_vec);
    end
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else if (!m_busy) begin
      m_hold = 1'b0;
      if (cfg_wr) m_baud = cfg_baud;
      if (exp_ready != '0) begin
        idx     = onehot_idx(exp_ready);
        m_busy  = 1'b1;
        m_pos   = 0;
        m_byte  = req_data[8*idx +: 8];
        m_grant = idx;
      end
    end else begin
      if (cfg_wr) begin m_pend_valid = 1'b1; m_pend = cfg_baud; end
      if (s_tick) m_pos++;
      if (m_pos == FRAME_TICKS) begin
        m_busy = 1'b0;
        if (m_pend_valid) begin m_baud = m_pend; m_pend_valid = 1'b0; m_hold = 1'b1; end
      end
    end
    #1;
  endtask

  task automatic start_frame(input logic [NREQ-1:0] who, input string tag);
    bit got;
    got = 0;
    req_valid = who; req_data = $urandom; s_tick = 1'b1; cfg_wr = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      step(tag);
      got = (obs_ready != '0);
    end
    req_valid = '0;
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL %s_accept: no ready within 10 cycles", tag); end
  endtask

  task automatic drain(input string tag);
    s_tick = 1'b1;
    for (int c = 0; c < 600; c++) begin
      step(tag);
      if (!obs_busy) break;
    end
    n_tests++;
    if (obs_busy) begin n_fail++; $display("FAIL %s_drain: busy=%b after 600 cycles want 0", tag, obs_busy); end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 4'($urandom) | 4'b0001; s_tick = 1'b1; cfg_wr = 1'b0;
    repeat (3) step("reset_hold");
    n_tests++; if (obs_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", obs_ready); end
    n_tests++; if (obs_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", obs_tx); end
    n_tests++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", obs_busy); end
    n_tests++; if (obs_baud !== 2'b00) begin n_fail++; $display("FAIL reset_baud: got %b want 00", obs_baud); end
    n_tests++; if (obs_grant !== 2'd3) begin n_fail++; $display("FAIL reset_grant: got %0d want 3", obs_grant); end
    reset = 1'b0; req_valid = '0;
    step("reset_release");
  endtask

  task automatic test_single();
    logic [9:0] want_bits;
    int  seen_ready, nsamp, nbad;
    bit  started, done;
    want_bits = {1'b1, 8'hA5, 1'b0};
    seen_ready = 0; nsamp = 0; nbad = 0; started = 0; done = 0;
    req_data = $urandom; req_data[7:0] = 8'hA5; req_valid = 4'b0001;
    for (int c = 0; c < 1000 && !done; c++) begin
      s_tick = 1'($urandom_range(0, 1));
      step("single");
      if (obs_ready != '0) begin seen_ready++; req_valid = '0; end
      if (obs_busy) begin
        started = 1;
        if (s_tick) begin
          if (nsamp < FRAME_TICKS && obs_tx !== want_bits[nsamp/16]) nbad++;
          nsamp++;
        end
      end else if (started) done = 1;
    end
    n_tests++; if (!done) begin n_fail++; $display("FAIL single_done: frame did not finish in 1000 cycles"); end
    n_tests++; if (seen_ready !== 1) begin n_fail++; $display("FAIL single_ready_count: got %0d want 1", seen_ready); end
    n_tests++; if (nsamp !== FRAME_TICKS) begin n_fail++; $display("FAIL single_ticks: got %0d want %0d", nsamp, FRAME_TICKS); end
    n_tests++; if (nbad !== 0) begin n_fail++; $display("FAIL single_bits: %0d tick samples differ from 0,1,0,1,0,0,1,0,1,1", nbad); end
    n_tests++; if (obs_grant !== 2'd0) begin n_fail++; $display("FAIL single_grant: got %0d want 0", obs_grant); end
  endtask

  task automatic test_round_robin();
    int got[$];
    int want[5] = '{0, 1, 2, 3, 0};
    int idx;
    reset = 1'b1; step("rr_reset"); reset = 1'b0;
    req_valid = 4'hF; req_data = $urandom; s_tick = 1'b1;
    for (int c = 0; c < 3000 && got.size() < 5; c++) begin
      step("rr");
      if (obs_ready != '0) begin
        idx = onehot_idx(obs_ready);
        got.push_back(idx);
        req_data[8*idx +: 8] = 8'($urandom);
      end
    end
    req_valid = '0;
    n_tests++;
    if (got.size() != 5) begin
      n_fail++; $display("FAIL rr_count: got %0d grants want 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (got[i] !== want[i]) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, got[i], want[i]); end
      end
    end
    drain("rr");
  endtask

  task automatic test_cfg_idle();
    req_valid = 4'b0100; cfg_wr = 1'b1; cfg_baud = 2'b10; s_tick = 1'b1;
    step("cfg_idle_wr");
    n_tests++; if (obs_ready !== 4'b0000) begin n_fail++; $display("FAIL cfg_idle_ready: got %b want 0000", obs_ready); end
    cfg_wr = 1'b0;
    step("cfg_idle_next");
    n_tests++; if (obs_baud !== 2'b10) begin n_fail++; $display("FAIL cfg_idle_baud: got %b want 10", obs_baud); end
    n_tests++; if (obs_ready !== 4'b0100) begin n_fail++; $display("FAIL cfg_idle_ready2: got %b want 0100", obs_ready); end
    req_valid = '0;
    drain("cfg_idle");
  endtask

  task automatic test_cfg_midframe();
    int bad;
    bad = 0;
    start_frame(4'b0010, "cfg_mid");
    repeat (50) step("cfg_mid");
    cfg_wr = 1'b1; cfg_baud = 2'b11;
    step("cfg_mid_wr");
    cfg_wr = 1'b0; req_valid = 4'b0001;
    for (int c = 0; c < 400; c++) begin
      step("cfg_mid_run");
      if (!obs_busy) break;
      if (obs_baud !== 2'b10) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL cfg_mid_hold: baud moved in %0d busy cycles want 0", bad); end
    n_tests++; if (obs_baud !== 2'b11) begin n_fail++; $display("FAIL cfg_mid_apply: got %b want 11", obs_baud); end
    n_tests++; if (obs_ready !== 4'b0000) begin n_fail++; $display("FAIL cfg_mid_noready: got %b want 0000", obs_ready); end
    step("cfg_mid_after");
    n_tests++; if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL cfg_mid_ready: got %b want 0001", obs_ready); end
    req_valid = '0;
    drain("cfg_mid");
  endtask

  task automatic test_cfg_double();
    int bad;
    bad = 0;
    start_frame(4'b1000, "cfg_dbl");
    repeat (30) step("cfg_dbl");
    cfg_wr = 1'b1; cfg_baud = 2'b01; step("cfg_dbl_wr1"); cfg_wr = 1'b0;
    repeat (60) step("cfg_dbl");
    cfg_wr = 1'b1; cfg_baud = 2'b10; step("cfg_dbl_wr2"); cfg_wr = 1'b0;
    for (int c = 0; c < 400; c++) begin
      step("cfg_dbl_run");
      if (!obs_busy) break;
      if (obs_baud !== 2'b11) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL cfg_dbl_hold: baud moved in %0d busy cycles want 0", bad); end
    n_tests++; if (obs_baud !== 2'b10) begin n_fail++; $display("FAIL cfg_dbl_apply: got %b want 10", obs_baud); end
    step("cfg_dbl_after");
  endtask

  task automatic test_reset_midframe();
    start_frame(4'b0100, "rst_mid");
    repeat (16*4 + 5) step("rst_mid_run");
    n_tests++; if (obs_busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b want 1", obs_busy); end
    reset = 1'b1; req_valid = 4'hF;
    step("rst_mid_pulse");
    reset = 1'b0;
    step("rst_mid_after");
    n_tests++; if (obs_tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx: got %b want 1", obs_tx); end
    n_tests++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", obs_busy); end
    n_tests++; if (obs_baud !== 2'b00) begin n_fail++; $display("FAIL rst_mid_baud: got %b want 00", obs_baud); end
    n_tests++; if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_first_grant: got %b want 0001", obs_ready); end
    req_valid = '0;
    step("rst_mid_grant");
    n_tests++; if (obs_grant !== 2'd0) begin n_fail++; $display("FAIL rst_mid_grant_id: got %0d want 0", obs_grant); end
    drain("rst_mid");
  endtask

  task automatic test_tick_stall();
    logic held_tx;
    int   bad;
    bad = 0;
    start_frame(4'b1000, "stall");
    repeat (40) step("stall_run");
    s_tick = 1'b0;
    step("stall_first");
    held_tx = obs_tx;
    repeat (60) begin
      step("stall_hold");
      if (obs_tx !== held_tx || obs_busy !== 1'b1) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL stall_frozen: %0d cycles changed want 0", bad); end
    drain("stall_resume");
  endtask

  task automatic test_random();
    req_valid = '0; cfg_wr = 1'b0; reset = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      step("random");
      for (int i = 0; i < NREQ; i++) begin
        if (obs_ready[i]) req_valid[i] = 1'b0;
        else if (req_valid[i] && $urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end
      end
      cfg_wr   = ($urandom_range(0, 59) == 0);
      cfg_baud = 2'($urandom);
      reset    = ($urandom_range(0, 1499) == 0);
      s_tick   = 1'($urandom_range(0, 1));
    end
    reset = 1'b0; cfg_wr = 1'b0; req_valid = '0;
    drain("random");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; s_tick = 1'b0;
    cfg_wr = 1'b0; cfg_baud = 2'b00;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_cfg_idle();
    test_cfg_midframe();
    test_cfg_double();
    test_reset_midframe();
    test_tick_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
